vend_sale_sequencer: RTL and testbench

Controller that sequences a completed sale for the vending machine datapath. It arbitrates between the two buy buttons, latches credit at grant, and commands the credit accumulator to clear. It then runs the product motor and pays change coin by coin through a req/ack hopper handshake. It sits between the coin accumulator, which supplies credit, and the motor and hopper drivers.

---
 rtl/vend_sale_sequencer.sv | 200 ++++++++++++++++++++
 tb/tb_vend_sale_sequencer.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/vend_sale_sequencer.sv
// Sale sequencer: arbitrates buy buttons, latches change, runs motor, pays change coin by coin.
// Latency: grant registered (clear_credit/motor one cycle after request); one coin per hopper handshake.
// Backpressure: motor_done and hopper_ack gate progress; bounded by MOTOR_TIMEOUT/ACK_TIMEOUT, else sticky FAULT.
module vend_sale_sequencer #(
  parameter int WIDTH         = 4,
  parameter int PRICE_A       = 2,
  parameter int PRICE_B       = 3,
  parameter int MOTOR_TIMEOUT = 8,
  parameter int ACK_TIMEOUT   = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] credit,
  input  logic             comprarA,
  input  logic             comprarB,
  input  logic             motor_done,
  input  logic             hopper_ack,
  output logic             clear_credit,
  output logic             motor_a,
  output logic             motor_b,
  output logic             hopper_req,
  output logic             hopper_coin,
  output logic [WIDTH-1:0] change_left,
  output logic             listoA,
  output logic             listoB,
  output logic             busy,
  output logic             fault
);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_VEND   = 3'd1,
    ST_CHANGE = 3'd2,
    ST_DONE   = 3'd3,
    ST_FAULT  = 3'd4
  } state_t;

  // One counter serves both the motor wait and the per-coin ack wait.
  localparam int TMAX = (MOTOR_TIMEOUT > ACK_TIMEOUT) ? MOTOR_TIMEOUT : ACK_TIMEOUT;
  localparam int CW   = $clog2(TMAX + 1);

  localparam logic [WIDTH-1:0] PRICE_A_W  = WIDTH'(PRICE_A);
  localparam logic [WIDTH-1:0] PRICE_B_W  = WIDTH'(PRICE_B);
  localparam logic [WIDTH-1:0] ONE_W      = WIDTH'(1);
  localparam logic [WIDTH-1:0] TWO_W      = WIDTH'(2);
  localparam logic [WIDTH-1:0] ZERO_W     = '0;
  localparam logic [CW-1:0]    MOTOR_LAST = CW'(MOTOR_TIMEOUT - 1);
  localparam logic [CW-1:0]    ACK_LAST   = CW'(ACK_TIMEOUT - 1);
  localparam logic [CW-1:0]    CNT_ONE    = CW'(1);

  // Product select encoding, shared by sel and rr_last.
  localparam logic SEL_A = 1'b0;
  localparam logic SEL_B = 1'b1;

  state_t           state_q, state_d;
  logic             sel_q, sel_d;          // product being sold
  logic             rr_last_q, rr_last_d;  // last product granted
  logic [WIDTH-1:0] change_q, change_d;    // change still owed
  logic [CW-1:0]    cnt_q, cnt_d;          // wait-cycle counter
  logic             req_q, req_d;          // hopper request
  logic             coin_q, coin_d;        // 1 = two-unit coin
  logic             clr_q, clr_d;          // clear_credit pulse

  logic             elig_a;
  logic             elig_b;
  logic             grant_b;
  logic [WIDTH-1:0] coin_val;

  // Eligibility and round-robin pick: B wins only if A is not eligible or A went last.
  always_comb begin
    elig_a  = comprarA && (credit >= PRICE_A_W);
    elig_b  = comprarB && (credit >= PRICE_B_W);
    grant_b = elig_b && (!elig_a || (rr_last_q == SEL_A));
  end

  // Next-state and register updates for the sale sequence.
  always_comb begin
    state_d   = state_q;
    sel_d     = sel_q;
    rr_last_d = rr_last_q;
    change_d  = change_q;
    cnt_d     = cnt_q;
    req_d     = req_q;
    coin_d    = coin_q;
    clr_d     = 1'b0;
    coin_val  = coin_q ? TWO_W : ONE_W;

    case (state_q)
      ST_IDLE: begin
        if (elig_a || elig_b) begin
          sel_d     = grant_b;
          rr_last_d = grant_b;
          change_d  = credit - (grant_b ? PRICE_B_W : PRICE_A_W);
          clr_d     = 1'b1;
          cnt_d     = '0;
          state_d   = ST_VEND;
        end
      end

      ST_VEND: begin
        if (motor_done) begin
          cnt_d = '0;
          if (change_q != ZERO_W) begin
            // First coin is requested in the very first CHANGE cycle.
            req_d   = 1'b1;
            coin_d  = (change_q >= TWO_W);
            state_d = ST_CHANGE;
          end else begin
            state_d = ST_DONE;
          end
        end else if (cnt_q == MOTOR_LAST) begin
          state_d = ST_FAULT;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end

      ST_CHANGE: begin
        if (req_q) begin
          if (hopper_ack) begin
            // Coin paid: drop req for one gap cycle before the next coin.
            change_d = change_q - coin_val;
            req_d    = 1'b0;
            cnt_d    = '0;
            if (change_q == coin_val) begin
              state_d = ST_DONE;
            end
          end else if (cnt_q == ACK_LAST) begin
            req_d   = 1'b0;
            state_d = ST_FAULT;
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end else begin
          // Gap cycle: acks here are ignored; arm the next greedy coin.
          req_d  = 1'b1;
          coin_d = (change_q >= TWO_W);
          cnt_d  = '0;
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
      end

      ST_FAULT: begin
        // Sticky: change_left stays frozen showing the amount owed.
        req_d   = 1'b0;
        state_d = ST_FAULT;
      end

      default: begin
        state_d = ST_IDLE;
        req_d   = 1'b0;
      end
    endcase
  end

  // State and datapath registers with synchronous reset; A is favoured first after reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      sel_q     <= SEL_A;
      rr_last_q <= SEL_B;
      change_q  <= '0;
      cnt_q     <= '0;
      req_q     <= 1'b0;
      coin_q    <= 1'b0;
      clr_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      sel_q     <= sel_d;
      rr_last_q <= rr_last_d;
      change_q  <= change_d;
      cnt_q     <= cnt_d;
      req_q     <= req_d;
      coin_q    <= coin_d;
      clr_q     <= clr_d;
    end
  end

  // Outputs are decoded from registered state only, so they are glitch-free.
  assign clear_credit = clr_q;
  assign motor_a      = (state_q == ST_VEND) && (sel_q == SEL_A);
  assign motor_b      = (state_q == ST_VEND) && (sel_q == SEL_B);
  assign hopper_req   = req_q;
  assign hopper_coin  = req_q && coin_q;
  assign change_left  = change_q;
  assign listoA       = (state_q == ST_DONE) && (sel_q == SEL_A);
  assign listoB       = (state_q == ST_DONE) && (sel_q == SEL_B);
  assign busy         = (state_q != ST_IDLE);
  assign fault        = (state_q == ST_FAULT);

  // Structural invariants of the outputs.
  a_motor_excl: assert property (@(posedge clk) disable iff (reset) !(motor_a && motor_b));
  a_clr_pulse: assert property (@(posedge clk) disable iff (reset) clear_credit |=> !clear_credit);
  a_coin_stable: assert property (@(posedge clk) disable iff (reset)
    (hopper_req && !hopper_ack) |=> (!hopper_req || $stable(hopper_coin)));

endmodule

// File: tb/tb_vend_sale_sequencer.sv
// Bench for vend_sale_sequencer: vector table, corner sequences, randomized sales vs transaction model.
// Latency: checks sampled 1 time unit after each rising edge.
// Backpressure: bench plays motor/hopper with chosen delays; every wait is a fixed cycle count.
module tb_vend_sale_sequencer;

  localparam int W  = 4;
  localparam int PA = 2;
  localparam int PB = 3;
  localparam int MT = 8;
  localparam int AT = 6;

  logic         clk = 1'b0;
  logic         reset;
  logic [W-1:0] credit;
  logic         comprarA, comprarB, motor_done, hopper_ack;
  logic         clear_credit, motor_a, motor_b, hopper_req, hopper_coin;
  logic [W-1:0] change_left;
  logic         listoA, listoB, busy, fault;

  int    n_chk = 0;
  int    n_err = 0;
  int    m_rr  = 2;   // model: last product granted (1=A, 2=B)
  string ctx   = "";

  vend_sale_sequencer #(
    .WIDTH(W), .PRICE_A(PA), .PRICE_B(PB), .MOTOR_TIMEOUT(MT), .ACK_TIMEOUT(AT)
  ) dut (
    .clk(clk), .reset(reset), .credit(credit),
    .comprarA(comprarA), .comprarB(comprarB),
    .motor_done(motor_done), .hopper_ack(hopper_ack),
    .clear_credit(clear_credit), .motor_a(motor_a), .motor_b(motor_b),
    .hopper_req(hopper_req), .hopper_coin(hopper_coin), .change_left(change_left),
    .listoA(listoA), .listoB(listoB), .busy(busy), .fault(fault)
  );

  always #5 clk = ~clk;

  typedef struct {
    int cr; bit a; bit b; int mdly; int adly; int eg; int echg;
  } vec_t;

  vec_t tbl[8];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s/%s: got %0d expected %0d", ctx, nm, act, exp);
    end
  endtask

  task automatic chk_all_zero();
    chk("clr", clear_credit, 0); chk("mot", {motor_a, motor_b}, 0);
    chk("req", hopper_req, 0);   chk("coin", hopper_coin, 0);
    chk("chg", change_left, 0);  chk("listo", {listoA, listoB}, 0);
    chk("busy", busy, 0);        chk("fault", fault, 0);
  endtask

  task automatic do_reset();
    reset = 1'b1; comprarA = 1'b0; comprarB = 1'b0;
    motor_done = 1'b0; hopper_ack = 1'b0; credit = '0;
    step();
    reset = 1'b0;
    m_rr = 2;
  endtask

  // Transaction-level model: which product is sold and how much change is owed.
  task automatic model_grant(input int cr, input bit a, input bit b, output int g, output int chg);
    bit ea, eb;
    ea = a && (cr >= PA);
    eb = b && (cr >= PB);
    if (ea && eb) g = (m_rr == 1) ? 2 : 1;
    else if (ea)  g = 1;
    else if (eb)  g = 2;
    else          g = 0;
    chg = 0;
    if (g != 0) begin
      m_rr = g;
      chg  = cr - ((g == 1) ? PA : PB);
    end
  endtask

  // One full sale attempt; eg: 0 none, 1 A, 2 B. Coins are expected greedily (2s, then a 1).
  task automatic sale(input int cr, input bit a, input bit b, input bit hold,
                      input int mdly, input int adly, input int eg, input int echg);
    int rem;
    int coin;
    credit = W'(cr); comprarA = a; comprarB = b;
    step();
    if (!hold) begin comprarA = 1'b0; comprarB = 1'b0; end
    credit = W'(cr + 7);   // must not disturb latched change
    if (eg == 0) begin
      chk("nogrant_busy", busy, 0);
      chk("nogrant_clr", clear_credit, 0);
      chk("nogrant_mot", {motor_a, motor_b}, 0);
      return;
    end
    chk("grant_clr", clear_credit, 1);
    chk("grant_mot", {motor_a, motor_b}, (eg == 1) ? 2 : 1);
    chk("grant_chg", change_left, echg);
    chk("grant_busy", busy, 1);
    for (int k = 1; k <= mdly; k++) begin
      motor_done = (k == mdly);
      step();
      if (k == 1) chk("clr_pulse", clear_credit, 0);
      if (k < mdly) chk("mot_hold", {motor_a, motor_b}, (eg == 1) ? 2 : 1);
    end
    motor_done = 1'b0;
    chk("mot_off", {motor_a, motor_b}, 0);
    chk("chg_keep", change_left, echg);
    rem = echg;
    while (rem > 0) begin
      coin = (rem >= 2) ? 2 : 1;
      chk("req_on", hopper_req, 1);
      chk("coin_val", hopper_coin, (coin == 2) ? 1 : 0);
      for (int j = 0; j < adly; j++) begin
        step();
        chk("req_wait", hopper_req, 1);
        chk("coin_stable", hopper_coin, (coin == 2) ? 1 : 0);
      end
      hopper_ack = 1'b1;
      step();
      hopper_ack = 1'b0;
      rem -= coin;
      chk("chg_dec", change_left, rem);
      chk("req_gap", hopper_req, 0);
      if (rem > 0) step();
    end
    chk("no_req", hopper_req, 0);
    chk("listo", {listoA, listoB}, (eg == 1) ? 2 : 1);
    chk("done_busy", busy, 1);
    step();
    chk("listo_pulse", {listoA, listoB}, 0);
    chk("idle_busy", busy, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int g, chg, cr, md, ad;
    bit a, b;

    tbl[0] = '{5,  1'b1, 1'b0, 3, 1, 1, 3};
    tbl[1] = '{3,  1'b0, 1'b1, 2, 0, 2, 0};
    tbl[2] = '{1,  1'b1, 1'b0, 0, 0, 0, 0};
    tbl[3] = '{2,  1'b0, 1'b1, 0, 0, 0, 0};
    tbl[4] = '{2,  1'b1, 1'b1, 1, 0, 1, 0};
    tbl[5] = '{15, 1'b1, 1'b1, 8, 2, 2, 12};
    tbl[6] = '{4,  1'b1, 1'b1, 4, 5, 1, 2};
    tbl[7] = '{0,  1'b1, 1'b1, 0, 0, 0, 0};

    ctx = "reset";
    do_reset();
    chk_all_zero();

    foreach (tbl[i]) begin
      ctx = $sformatf("tbl%0d", i);
      sale(tbl[i].cr, tbl[i].a, tbl[i].b, 1'b0, tbl[i].mdly, tbl[i].adly, tbl[i].eg, tbl[i].echg);
    end

    // Both buttons held at credit 8: one sale per pass, alternating A, B, A.
    do_reset();
    ctx = "held1"; sale(8, 1'b1, 1'b1, 1'b1, 2, 1, 1, 6);
    ctx = "held2"; sale(8, 1'b1, 1'b1, 1'b1, 1, 0, 2, 5);
    ctx = "held3"; sale(8, 1'b1, 1'b1, 1'b1, 3, 2, 1, 6);
    comprarA = 1'b0; comprarB = 1'b0;

    // Motor never finishes: FAULT after MT VEND cycles, change kept, only reset clears.
    ctx = "mot_to";
    do_reset();
    credit = 4'd4; comprarA = 1'b1;
    step();
    comprarA = 1'b0;
    chk("mot_on", motor_a, 1);
    for (int i = 1; i < MT; i++) begin
      step();
      chk("mot_on", motor_a, 1);
      chk("no_fault", fault, 0);
    end
    step();
    chk("fault", fault, 1);
    chk("mot_off", motor_a, 0);
    chk("chg", change_left, 2);
    for (int i = 0; i < 3; i++) step();
    chk("sticky", fault, 1);
    chk("sticky_chg", change_left, 2);
    chk("busy", busy, 1);
    do_reset();
    chk_all_zero();

    // Hopper never acks the first coin: FAULT after AT request cycles, 3 still owed.
    ctx = "ack_to";
    credit = 4'd6; comprarB = 1'b1;
    step();
    comprarB = 1'b0;
    chk("mot_b", motor_b, 1);
    chk("chg", change_left, 3);
    motor_done = 1'b1;
    step();
    motor_done = 1'b0;
    chk("req", hopper_req, 1);
    chk("coin", hopper_coin, 1);
    for (int i = 1; i < AT; i++) begin
      step();
      chk("req_hold", hopper_req, 1);
      chk("no_fault", fault, 0);
    end
    step();
    chk("fault", fault, 1);
    chk("req_off", hopper_req, 0);
    chk("chg", change_left, 3);
    do_reset();
    chk_all_zero();

    // Ack while no request is ignored; reset in CHANGE abandons the handshake.
    ctx = "mid_rst";
    credit = 4'd5; comprarA = 1'b1; hopper_ack = 1'b1;
    step();
    comprarA = 1'b0;
    step();
    chk("chg_vend", change_left, 3);
    motor_done = 1'b1;
    step();
    motor_done = 1'b0; hopper_ack = 1'b0;
    chk("chg_kept", change_left, 3);
    chk("req", hopper_req, 1);
    step();
    chk("req_wait", hopper_req, 1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    m_rr = 2;
    chk_all_zero();
    ctx = "post_rst";
    sale(5, 1'b1, 1'b0, 1'b0, 1, 0, 1, 3);

    // Randomized sales against the transaction model.
    do_reset();
    for (int n = 0; n < 40; n++) begin
      cr = $urandom_range(0, 15);
      a  = 1'($urandom_range(0, 1));
      b  = 1'($urandom_range(0, 1));
      md = $urandom_range(1, MT);
      ad = $urandom_range(0, AT - 1);
      model_grant(cr, a, b, g, chg);
      ctx = $sformatf("rnd%0d", n);
      sale(cr, a, b, 1'b0, md, ad, g, chg);
      if ($urandom_range(0, 3) == 0) step();
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
